// File: rtl/reg_writeback_ctrl_if.sv
// rtl/reg_writeback_ctrl_if.sv - producer/consumer and register-file bundle for the writeback controller
interface reg_writeback_ctrl_if #(
    parameter int N          = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             alu_valid;
    logic             alu_ready;
    logic [4:0]       alu_rd;
    logic [N-1:0]     alu_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [4:0]       mem_rd;
    logic [N-1:0]     mem_data;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             rs1_busy;
    logic             rs2_busy;
    logic [N-1:0]     D;
    logic [4:0]       WriteReg;
    logic             RegWrite;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd, rs1, rs2,
        input  alu_ready, mem_ready, rs1_busy, rs2_busy,
        input  D, WriteReg, RegWrite, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd, rs1, rs2,
        output alu_ready, mem_ready, rs1_busy, rs2_busy,
        output D, WriteReg, RegWrite, fifo_count
    );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// rtl/reg_writeback_ctrl.sv - merges ALU/load results onto the register-file write port
// ALU results are buffered in a FIFO; a scoreboard tracks registers with writes in flight.
module reg_writeback_ctrl #(
    parameter int N          = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    reg_writeback_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
    logic [4:0]       fifo_rd_d   [FIFO_DEPTH];
    logic [N-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [N-1:0]     fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      busy_q, busy_d;
    logic [N-1:0]     d_q, d_d;
    logic [4:0]       wreg_q, wreg_d;
    logic             regwrite_q, regwrite_d;

    logic             full;
    logic             empty;
    logic             alu_ready;
    logic             mem_ready;
    logic             push;
    logic             pop;
    logic             commit;
    logic [4:0]       commit_rd;
    logic [N-1:0]     commit_data;

    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        alu_ready = !rst && !full;
        mem_ready = !rst && !full;
        push      = bus.alu_valid && alu_ready;

        // A full FIFO must drain first, otherwise a steady load stream could starve it forever.
        pop         = 1'b0;
        commit      = 1'b0;
        commit_rd   = '0;
        commit_data = '0;
        if (!rst) begin
            if (full) begin
                pop = 1'b1;
            end else if (bus.mem_valid) begin
                commit      = 1'b1;
                commit_rd   = bus.mem_rd;
                commit_data = bus.mem_data;
            end else if (!empty) begin
                pop = 1'b1;
            end
        end
        if (pop) begin
            commit      = 1'b1;
            commit_rd   = fifo_rd_q[rd_ptr_q];
            commit_data = fifo_data_q[rd_ptr_q];
        end

        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = bus.alu_rd;
            fifo_data_d[wr_ptr_q] = bus.alu_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear before set so a same-cycle re-issue of the committing rd stays busy.
        busy_d = busy_q;
        if (commit) begin
            busy_d[commit_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        d_d        = d_q;
        wreg_d     = wreg_q;
        regwrite_d = 1'b0;
        if (commit && (commit_rd != 5'd0)) begin
            d_d        = commit_data;
            wreg_d     = commit_rd;
            regwrite_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            d_q        <= '0;
            wreg_q     <= '0;
            regwrite_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            d_q        <= d_d;
            wreg_q     <= wreg_d;
            regwrite_q <= regwrite_d;
        end
    end

    assign bus.alu_ready  = alu_ready;
    assign bus.mem_ready  = mem_ready;
    assign bus.rs1_busy   = busy_q[bus.rs1];
    assign bus.rs2_busy   = busy_q[bus.rs2];
    assign bus.D          = d_q;
    assign bus.WriteReg   = wreg_q;
    assign bus.RegWrite   = regwrite_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb/tb_reg_writeback_ctrl.sv - directed self-checking bench for reg_writeback_ctrl
module tb_reg_writeback_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    reg_writeback_ctrl_if #(.N(32), .FIFO_DEPTH(4)) bus ();

    reg_writeback_ctrl #(.N(32), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (bus.alu_ready !== 1'b0) begin miscompares++; $display("FAIL rst_alu_ready got %0h exp 0", bus.alu_ready); end
        vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mem_ready got %0h exp 0", bus.mem_ready); end
        vectors++; if (bus.fifo_count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d exp 0", bus.fifo_count); end
        vectors++; if (bus.RegWrite !== 1'b0) begin miscompares++; $display("FAIL rst_regwrite got %0h exp 0", bus.RegWrite); end
        vectors++; if (bus.D !== 32'd0) begin miscompares++; $display("FAIL rst_d got %0h exp 0", bus.D); end
        vectors++; if (bus.WriteReg !== 5'd0) begin miscompares++; $display("FAIL rst_writereg got %0d exp 0", bus.WriteReg); end
        rst = 1'b0;
        #1;
        vectors++; if (bus.alu_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_alu_ready got %0h exp 1", bus.alu_ready); end
    endtask

    task automatic test_alu_commit();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hA5;
        tick();
        bus.alu_valid = 1'b0;
        vectors++; if (bus.fifo_count !== 3'd1) begin miscompares++; $display("FAIL alu_count1 got %0d exp 1", bus.fifo_count); end
        vectors++; if (bus.RegWrite !== 1'b0) begin miscompares++; $display("FAIL alu_early_write got %0h exp 0", bus.RegWrite); end
        tick();
        vectors++; if (bus.RegWrite !== 1'b1) begin miscompares++; $display("FAIL alu_regwrite got %0h exp 1", bus.RegWrite); end
        vectors++; if (bus.WriteReg !== 5'd5) begin miscompares++; $display("FAIL alu_writereg got %0d exp 5", bus.WriteReg); end
        vectors++; if (bus.D !== 32'hA5) begin miscompares++; $display("FAIL alu_d got %0h exp a5", bus.D); end
        vectors++; if (bus.fifo_count !== 3'd0) begin miscompares++; $display("FAIL alu_count0 got %0d exp 0", bus.fifo_count); end
        tick();
        vectors++; if (bus.RegWrite !== 1'b0) begin miscompares++; $display("FAIL idle_regwrite got %0h exp 0", bus.RegWrite); end
        vectors++; if (bus.D !== 32'hA5) begin miscompares++; $display("FAIL idle_d_hold got %0h exp a5", bus.D); end
    endtask

    task automatic test_scoreboard();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1 = 5'd7; bus.rs2 = 5'd0;
        tick();
        bus.issue_valid = 1'b0;
        vectors++; if (bus.rs1_busy !== 1'b1) begin miscompares++; $display("FAIL sb_rs1_set got %0h exp 1", bus.rs1_busy); end
        vectors++; if (bus.rs2_busy !== 1'b0) begin miscompares++; $display("FAIL sb_rs2_r0 got %0h exp 0", bus.rs2_busy); end
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        tick();
        bus.issue_valid = 1'b0;
        vectors++; if (bus.rs2_busy !== 1'b0) begin miscompares++; $display("FAIL sb_r0_hardwired got %0h exp 0", bus.rs2_busy); end
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h77;
        #1;
        vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("FAIL sb_mem_ready got %0h exp 1", bus.mem_ready); end
        tick();
        bus.mem_valid = 1'b0;
        vectors++; if (bus.rs1_busy !== 1'b0) begin miscompares++; $display("FAIL sb_rs1_clear got %0h exp 0", bus.rs1_busy); end
        vectors++; if (bus.WriteReg !== 5'd7) begin miscompares++; $display("FAIL sb_writereg got %0d exp 7", bus.WriteReg); end
        vectors++; if (bus.D !== 32'h77) begin miscompares++; $display("FAIL sb_d got %0h exp 77", bus.D); end
    endtask

    task automatic test_full();
        bus.mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(i + 1); bus.alu_data = 32'h100 + i;
            bus.mem_rd = 5'(10 + i); bus.mem_data = 32'h200 + i;
            #1;
            vectors++; if (bus.alu_ready !== 1'b1) begin miscompares++; $display("FAIL full_alu_ready%0d got %0h exp 1", i, bus.alu_ready); end
            tick();
            vectors++; if (bus.WriteReg !== 5'(10 + i)) begin miscompares++; $display("FAIL full_load_wr%0d got %0d exp %0d", i, bus.WriteReg, 10 + i); end
        end
        bus.alu_valid = 1'b0;
        bus.mem_rd = 5'd20; bus.mem_data = 32'h2020;
        vectors++; if (bus.fifo_count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d exp 4", bus.fifo_count); end
        vectors++; if (bus.alu_ready !== 1'b0) begin miscompares++; $display("FAIL full_alu_ready got %0h exp 0", bus.alu_ready); end
        vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("FAIL full_mem_ready got %0h exp 0", bus.mem_ready); end
        tick();
        vectors++; if (bus.WriteReg !== 5'd1) begin miscompares++; $display("FAIL full_head_wr got %0d exp 1", bus.WriteReg); end
        vectors++; if (bus.D !== 32'h100) begin miscompares++; $display("FAIL full_head_d got %0h exp 100", bus.D); end
        vectors++; if (bus.fifo_count !== 3'd3) begin miscompares++; $display("FAIL full_count3 got %0d exp 3", bus.fifo_count); end
        vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("FAIL full_mem_resume got %0h exp 1", bus.mem_ready); end
        tick();
        vectors++; if (bus.WriteReg !== 5'd20) begin miscompares++; $display("FAIL full_load_resume got %0d exp 20", bus.WriteReg); end
        vectors++; if (bus.fifo_count !== 3'd3) begin miscompares++; $display("FAIL full_hold_count got %0d exp 3", bus.fifo_count); end
        bus.mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.WriteReg !== 5'(i + 2)) begin miscompares++; $display("FAIL drain_wr%0d got %0d exp %0d", i, bus.WriteReg, i + 2); end
            vectors++; if (bus.D !== 32'h101 + i) begin miscompares++; $display("FAIL drain_d%0d got %0h exp %0h", i, bus.D, 32'h101 + i); end
        end
        vectors++; if (bus.fifo_count !== 3'd0) begin miscompares++; $display("FAIL drain_count got %0d exp 0", bus.fifo_count); end
        tick();
    endtask

    task automatic test_rd_zero();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hFFFF;
        #1;
        vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("FAIL rd0_mem_ready got %0h exp 1", bus.mem_ready); end
        tick();
        bus.mem_valid = 1'b0;
        vectors++; if (bus.RegWrite !== 1'b0) begin miscompares++; $display("FAIL rd0_regwrite got %0h exp 0", bus.RegWrite); end
        vectors++; if (bus.WriteReg !== 5'd4) begin miscompares++; $display("FAIL rd0_writereg got %0d exp 4", bus.WriteReg); end
        vectors++; if (bus.D !== 32'h103) begin miscompares++; $display("FAIL rd0_d got %0h exp 103", bus.D); end
    endtask

    task automatic test_set_wins();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.rs2 = 5'd9;
        tick();
        vectors++; if (bus.rs2_busy !== 1'b1) begin miscompares++; $display("FAIL sw_set got %0h exp 1", bus.rs2_busy); end
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
        tick();
        bus.issue_valid = 1'b0;
        vectors++; if (bus.rs2_busy !== 1'b1) begin miscompares++; $display("FAIL sw_set_wins got %0h exp 1", bus.rs2_busy); end
        vectors++; if (bus.WriteReg !== 5'd9) begin miscompares++; $display("FAIL sw_writereg got %0d exp 9", bus.WriteReg); end
        tick();
        bus.mem_valid = 1'b0;
        vectors++; if (bus.rs2_busy !== 1'b0) begin miscompares++; $display("FAIL sw_clear got %0h exp 0", bus.rs2_busy); end
    endtask

    task automatic test_reset_mid();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd12; bus.rs1 = 5'd12;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(20 + i); bus.alu_data = 32'h300 + i;
            tick();
            bus.issue_valid = 1'b0;
        end
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        vectors++; if (bus.fifo_count !== 3'd3) begin miscompares++; $display("FAIL mid_count3 got %0d exp 3", bus.fifo_count); end
        vectors++; if (bus.rs1_busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_pre got %0h exp 1", bus.rs1_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (bus.fifo_count !== 3'd0) begin miscompares++; $display("FAIL mid_count0 got %0d exp 0", bus.fifo_count); end
        vectors++; if (bus.rs1_busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy_clr got %0h exp 0", bus.rs1_busy); end
        vectors++; if (bus.WriteReg !== 5'd0) begin miscompares++; $display("FAIL mid_writereg got %0d exp 0", bus.WriteReg); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (bus.RegWrite !== 1'b0) begin miscompares++; $display("FAIL mid_no_write%0d got %0h exp 0", i, bus.RegWrite); end
        end
        vectors++; if (bus.fifo_count !== 3'd0) begin miscompares++; $display("FAIL mid_count_stay got %0d exp 0", bus.fifo_count); end
    endtask

    initial begin
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        test_reset();
        test_alu_commit();
        test_scoreboard();
        test_full();
        test_rd_zero();
        test_set_wins();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
